// File: rtl/ysyx_25040105_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040105_wb_arbiter
//  Description : Register scoreboard plus round-robin ALU/LSU write-back
//                arbiter. Tracks reserved destination registers, blocks
//                issue on RAW/WAW hazards and forwards the granted
//                write-back to a registered register-file write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040105_wb_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,        // asynchronous, active-low

   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rs1,
   input  logic [ADDR_WIDTH-1:0] iss_rs2,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   output logic                  iss_ready,

   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,

   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,

   input  logic                  flush,

   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,

   output logic [ADDR_WIDTH:0]   busy_cnt
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   // Round-robin pointer: which requester wins the next contended cycle.
   typedef enum logic {
      PRIO_ALU = 1'b0,
      PRIO_LSU = 1'b1
   } prio_e;

   prio_e                 r_prio;
   prio_e                 w_prio_nxt;
   logic [NREG-1:0]       r_busy;
   logic [NREG-1:0]       w_busy_nxt;
   logic [ADDR_WIDTH:0]   r_busy_cnt;
   logic [ADDR_WIDTH:0]   w_cnt_nxt;
   logic                  r_rf_wen;
   logic [ADDR_WIDTH-1:0] r_rf_waddr;
   logic [DATA_WIDTH-1:0] r_rf_wdata;

   logic                  w_alu_gnt;
   logic                  w_lsu_gnt;
   logic                  w_gnt;
   logic                  w_iss_fire;
   logic [ADDR_WIDTH-1:0] w_wb_rd;
   logic [DATA_WIDTH-1:0] w_wb_data;

   // Hazard check uses only the registered busy bits: no same-cycle release bypass.
   assign iss_ready  = ~(r_busy[iss_rs1] | r_busy[iss_rs2] | r_busy[iss_rd]);
   assign w_iss_fire = iss_valid & iss_ready;

   // Arbitration ignores busy state; the pointer only matters under contention.
   assign w_alu_gnt = alu_valid & (~lsu_valid | (r_prio == PRIO_ALU));
   assign w_lsu_gnt = lsu_valid & (~alu_valid | (r_prio == PRIO_LSU));
   assign w_gnt     = w_alu_gnt | w_lsu_gnt;
   assign w_wb_rd   = w_lsu_gnt ? lsu_rd   : alu_rd;
   assign w_wb_data = w_lsu_gnt ? lsu_data : alu_data;

   assign alu_ready = w_alu_gnt;
   assign lsu_ready = w_lsu_gnt;

   assign rf_wen   = r_rf_wen;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;
   assign busy_cnt = r_busy_cnt;

   // Pointer moves only on a contended grant and then points at the loser.
   always_comb begin
      w_prio_nxt = r_prio;
      if (alu_valid && lsu_valid) begin
         w_prio_nxt = w_alu_gnt ? PRIO_LSU : PRIO_ALU;
      end
   end

   // Next busy vector: release, then reserve (set wins), then flush overrides all.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_gnt) begin
         w_busy_nxt[w_wb_rd] = 1'b0;
      end
      if (w_iss_fire && (iss_rd != '0)) begin
         w_busy_nxt[iss_rd] = 1'b1;
      end
      if (flush) begin
         w_busy_nxt = '0;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Population count of the next busy vector so busy_cnt tracks r_busy exactly.
   always_comb begin
      w_cnt_nxt = '0;
      for (int i = 1; i < NREG; i++) begin
         w_cnt_nxt = w_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_busy_nxt[i]};
      end
   end

   // Scoreboard and arbitration pointer state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
         r_prio     <= PRIO_ALU;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
         r_prio     <= w_prio_nxt;
      end
   end

   // Registered write port; address/data hold when there is no grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rf_wen   <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_wen <= w_gnt && (w_wb_rd != '0);
         if (w_gnt) begin
            r_rf_waddr <= w_wb_rd;
            r_rf_wdata <= w_wb_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040105_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_25040105_wb_arbiter
//  Description : Self-checking bench for the write-back arbiter. A behavioural
//                scoreboard model is compared every cycle; directed scenarios
//                pin the model with hand-computed literals, then random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040105_wb_arbiter;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          iss_valid;
   logic [AW-1:0] iss_rs1, iss_rs2, iss_rd;
   logic          iss_ready;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic          lsu_valid;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          lsu_ready;
   logic          flush;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW:0]   busy_cnt;

   int errors = 0;
   int checks = 0;

   ysyx_25040105_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .lsu_valid (lsu_valid),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .lsu_ready (lsu_ready),
      .flush     (flush),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [NREG-1:0] m_busy  = '0;
   logic            m_prio  = 1'b0;   // 0: ALU wins a tie, 1: LSU wins a tie
   logic            m_wen   = 1'b0;
   logic [AW-1:0]   m_waddr = '0;
   logic [DW-1:0]   m_wdata = '0;

   // 0 = nobody, 1 = ALU, 2 = LSU
   function automatic int winner();
      if (alu_valid && lsu_valid) return m_prio ? 2 : 1;
      if (alu_valid) return 1;
      if (lsu_valid) return 2;
      return 0;
   endfunction

   function automatic logic exp_iss_ready();
      return !(m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
   endfunction

   function automatic logic [NREG-1:0] next_busy();
      logic [NREG-1:0] nb;
      int w;
      nb = m_busy;
      w  = winner();
      if (w == 1) nb[alu_rd] = 1'b0;
      if (w == 2) nb[lsu_rd] = 1'b0;
      if (iss_valid && exp_iss_ready() && iss_rd != 0) nb[iss_rd] = 1'b1;
      if (flush) nb = '0;
      nb[0] = 1'b0;
      return nb;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy  <= '0;
         m_prio  <= 1'b0;
         m_wen   <= 1'b0;
         m_waddr <= '0;
         m_wdata <= '0;
      end else begin
         m_busy <= next_busy();
         if (alu_valid && lsu_valid) m_prio <= (winner() == 1);
         if (winner() == 1) begin
            m_wen   <= (alu_rd != 0);
            m_waddr <= alu_rd;
            m_wdata <= alu_data;
         end else if (winner() == 2) begin
            m_wen   <= (lsu_rd != 0);
            m_waddr <= lsu_rd;
            m_wdata <= lsu_data;
         end else begin
            m_wen <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("iss_ready", 64'(iss_ready), 64'(exp_iss_ready()));
      chk("alu_ready", 64'(alu_ready), 64'(winner() == 1));
      chk("lsu_ready", 64'(lsu_ready), 64'(winner() == 2));
      chk("rf_wen",    64'(rf_wen),    64'(m_wen));
      chk("rf_waddr",  64'(rf_waddr),  64'(m_waddr));
      chk("rf_wdata",  64'(rf_wdata),  64'(m_wdata));
      chk("busy_cnt",  64'(busy_cnt),  64'($countones(m_busy)));
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic look();
      @(negedge clk); #1;
   endtask

   task automatic issue(input logic [AW-1:0] rd);
      iss_valid = 1'b1; iss_rs1 = '0; iss_rs2 = '0; iss_rd = rd;
   endtask

   task automatic reset_dut();
      idle();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1;
      tick();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic ag, lg;
      idle();
      rst = 1'b0;
      #2;
      chk("reset_rf_wen",   64'(rf_wen),   64'd0);
      chk("reset_waddr",    64'(rf_waddr), 64'd0);
      chk("reset_wdata",    64'(rf_wdata), 64'd0);
      chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
      chk("reset_iss_rdy",  64'(iss_ready), 64'd1);
      reset_dut();

      // RAW hazard then release via ALU write-back
      issue(5);
      look(); chk("raw_first_ready", 64'(iss_ready), 64'd1);
      tick();
      iss_valid = 1'b1; iss_rs1 = 5; iss_rs2 = 0; iss_rd = 0;
      alu_valid = 1'b1; alu_rd = 5; alu_data = 32'h1234;
      look();
      chk("raw_blocked",  64'(iss_ready), 64'd0);
      chk("raw_cnt1",     64'(busy_cnt),  64'd1);
      chk("raw_alu_gnt",  64'(alu_ready), 64'd1);
      tick();
      iss_valid = 1'b0; alu_valid = 1'b0;
      look();
      chk("wb_wen",      64'(rf_wen),    64'd1);
      chk("wb_waddr",    64'(rf_waddr),  64'd5);
      chk("wb_wdata",    64'(rf_wdata),  64'h1234);
      chk("raw_release", 64'(iss_ready), 64'd1);
      tick();

      // Round robin from reset: ALU, LSU, ALU
      reset_dut();
      alu_valid = 1'b1; alu_rd = 1; alu_data = 32'hA1;
      lsu_valid = 1'b1; lsu_rd = 2; lsu_data = 32'hB2;
      look(); chk("rr1_alu", 64'(alu_ready), 64'd1); chk("rr1_lsu", 64'(lsu_ready), 64'd0);
      tick();
      alu_rd = 3; alu_data = 32'hA3;
      look(); chk("rr2_alu", 64'(alu_ready), 64'd0); chk("rr2_lsu", 64'(lsu_ready), 64'd1);
      tick();
      lsu_rd = 4; lsu_data = 32'hB4;
      look(); chk("rr3_alu", 64'(alu_ready), 64'd1); chk("rr3_lsu", 64'(lsu_ready), 64'd0);
      tick();
      idle();

      // x0 is never reserved and never written
      reset_dut();
      issue(0);
      tick();
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 0; alu_data = 32'h55;
      look(); chk("x0_cnt", 64'(busy_cnt), 64'd0); chk("x0_alu_gnt", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      look(); chk("x0_no_wen", 64'(rf_wen), 64'd0); chk("x0_cnt2", 64'(busy_cnt), 64'd0);
      tick();

      // Flush wipes reservations and beats a same-cycle issue
      issue(3); tick();
      issue(4); tick();
      issue(7); tick();
      iss_valid = 1'b0;
      look(); chk("pre_flush_cnt", 64'(busy_cnt), 64'd3);
      issue(9); flush = 1'b1;
      tick();
      iss_valid = 1'b0; flush = 1'b0;
      look(); chk("flush_cnt", 64'(busy_cnt), 64'd0); chk("flush_x9_free", 64'(iss_ready), 64'd1);
      tick();

      // Set wins over same-cycle clear
      issue(8);
      lsu_valid = 1'b1; lsu_rd = 8; lsu_data = 32'h77;
      look(); chk("sw_lsu_gnt", 64'(lsu_ready), 64'd1);
      tick();
      idle(); iss_rd = 8;
      look(); chk("sw_cnt", 64'(busy_cnt), 64'd1); chk("sw_x8_busy", 64'(iss_ready), 64'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // Asynchronous reset mid-cycle
      issue(11); tick();
      idle();
      alu_valid = 1'b1; alu_rd = 2; alu_data = 32'hAB;
      tick();
      look(); chk("pre_rst_wen", 64'(rf_wen), 64'd1);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("arst_wen",   64'(rf_wen),    64'd0);
      chk("arst_cnt",   64'(busy_cnt),  64'd0);
      chk("arst_waddr", 64'(rf_waddr),  64'd0);
      chk("arst_ready", 64'(alu_ready), 64'd1);
      look();
      rst = 1'b1;
      lsu_valid = 1'b1; lsu_rd = 3; lsu_data = 32'hCD;
      #1;
      chk("post_rst_alu", 64'(alu_ready), 64'd1);
      chk("post_rst_lsu", 64'(lsu_ready), 64'd0);
      tick();
      idle();

      // Randomized traffic; requesters hold until granted
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ag = alu_valid & alu_ready;
         lg = lsu_valid & lsu_ready;
         @(posedge clk); #1;
         if (!alu_valid || ag) begin
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd    = AW'($urandom_range(0, 15));
            alu_data  = $urandom;
         end
         if (!lsu_valid || lg) begin
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_rd    = AW'($urandom_range(0, 15));
            lsu_data  = $urandom;
         end
         iss_valid = ($urandom_range(0, 1) != 0);
         iss_rs1   = AW'($urandom_range(0, 15));
         iss_rs2   = AW'($urandom_range(0, 15));
         iss_rd    = AW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, NREG - 1)
                                                     : $urandom_range(0, 15));
         flush     = ($urandom_range(0, 47) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2;
            rst = 1'b0;
            alu_valid = 1'b0;
            lsu_valid = 1'b0;
            @(negedge clk); #1;
            rst = 1'b1;
         end
      end

      idle();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ysyx_25040105_wb_arbiter.md
YSYX_25040105_WB_ARBITER -- requirements
Module: ysyx_25040105_wb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the register address width (2**ADDR_WIDTH registers).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the write-back data width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, the asynchronous active-low reset.
REQ-006 Port iss_valid, input, 1, the issue stage presents an instruction.
REQ-007 Ports iss_rs1 / iss_rs2 / iss_rd, input, ADDR_WIDTH each, the instruction's source and destination registers.
REQ-008 Port iss_ready, output, 1, the instruction may issue; iss_fire = iss_valid & iss_ready.
REQ-009 Ports alu_valid, alu_rd, alu_data, inputs (1 / ADDR_WIDTH / DATA_WIDTH), the ALU write-back request.
REQ-010 Port alu_ready, output, 1, the ALU request is granted this cycle.
REQ-011 Ports lsu_valid, lsu_rd, lsu_data, inputs (1 / ADDR_WIDTH / DATA_WIDTH), the LSU write-back request.
REQ-012 Port lsu_ready, output, 1, the LSU request is granted this cycle.
REQ-013 Port flush, input, 1, a synchronous clear of all reservations.
REQ-014 Ports rf_wen / rf_waddr / rf_wdata, outputs (1 / ADDR_WIDTH / DATA_WIDTH), the registered register-file write port.
REQ-015 Port busy_cnt, output, ADDR_WIDTH+1, the number of reserved registers.

Function
REQ-016 The block SHALL keep a busy bit for each register 1..2**ADDR_WIDTH-1; the bit for register 0 SHALL read as 0 at all times.
REQ-017 iss_ready SHALL be the combinational value !(busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]), covering RAW and WAW hazards.
REQ-018 iss_ready SHALL be computed from the current busy bits only; a release in the same cycle SHALL NOT be bypassed.
REQ-019 On iss_fire with iss_rd != 0, the block SHALL set busy[iss_rd] at the next edge.
REQ-020 On iss_fire with iss_rd == 0, the block SHALL reserve nothing.
REQ-021 A single round-robin pointer, prio (0 = ALU, 1 = LSU), SHALL arbitrate between the two requesters.
REQ-022 If only one requester is valid, that requester SHALL be granted.
REQ-023 If both requesters are valid, the requester selected by prio SHALL be granted; the other SHALL see ready = 0 and hold its request.
REQ-024 prio SHALL change only on a contended grant, and SHALL then point to the loser.
REQ-025 At most one grant SHALL occur per cycle, and a grant SHALL NOT depend on busy state.
REQ-026 On a grant, the block SHALL clear busy[rd] at the next edge.
REQ-027 On a grant, the next cycle SHALL have rf_wen = (rd != 0), rf_waddr = rd and rf_wdata = data; latency is 1 cycle.
REQ-028 With no grant, the next cycle SHALL have rf_wen = 0, while rf_waddr and rf_wdata hold their previous values.
REQ-029 If a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-030 flush SHALL clear all busy bits at the next edge and SHALL override same-cycle sets.
REQ-031 A grant in a flush cycle SHALL still produce its rf write.
REQ-032 busy_cnt SHALL be the registered population count of the busy bits, ranging 0..2**ADDR_WIDTH-1, with no wrap.

Reset
REQ-033 While rst = 0, the block SHALL asynchronously drive busy = 0, prio = 0 (ALU), rf_wen = 0, rf_waddr = 0, rf_wdata = 0 and busy_cnt = 0.
REQ-034 A reset asserted mid-operation SHALL drop pending requests and reservations, with no rf write.
REQ-035 Ready outputs SHALL follow the reset busy state combinationally.
REQ-036 Normal operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-037 Issue rd=5, then in the next cycle present rs1=5: iss_ready = 0 and busy_cnt = 1; ALU write-back rd=5, data=0x1234 granted: the next cycle has rf_wen = 1, waddr = 5, wdata = 0x1234, and then iss_ready = 1.
REQ-038 From reset, ALU and LSU both valid for 3 cycles, with 1-cycle handshakes and fresh rds: grants go ALU, LSU, ALU.
REQ-039 Issue rd=0, then ALU write-back rd=0: busy_cnt stays 0, alu_ready = 1, rf_wen = 0.
REQ-040 Reserve x3, x4 and x7, then pulse flush in the same cycle as an issue of rd=9: busy_cnt = 0 afterwards and busy[9] = 0.
REQ-041 Issue rd=8 in the same cycle as an LSU write-back to rd=8 (with busy[8] previously clear): busy[8] = 1 afterwards.
REQ-042 Assert rst low mid-cycle while ALU is valid with rd=2: rf_wen = 0 immediately, busy_cnt = 0, and prio = ALU after release.
